txn_guard_unit: RTL

Parametrised, passive transaction-timeout guard for one AXI direction (AW/B or AR/R); the parent instantiates one per direction. It tracks up to NumSlots outstanding transactions, each with its own ID, address and age counter. It detects timeouts, outstanding-table overflow and unmatched responses. A fault sequence then runs: interrupt, isolation request, reset request/handshake, flush. It succeeds the single-budget guard with multi-slot tracking, fault causes, an isolation output and a selectable reset mode.

---
 rtl/txn_guard_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/txn_guard_unit.sv
// Passive AXI transaction-timeout guard for one direction.
// Multi-slot outstanding tracking with fault capture, isolation and reset handshake.
module txn_guard_unit #(
    parameter int NumSlots  = 8,
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 32,
    parameter int CntWidth  = 16,
    parameter bit AutoReset = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           guard_ena_i,
    input  logic [CntWidth-1:0]            budget_i,
    input  logic                           req_valid_i,
    input  logic                           req_ready_i,
    input  logic [IdWidth-1:0]             req_id_i,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic                           rsp_valid_i,
    input  logic                           rsp_ready_i,
    input  logic [IdWidth-1:0]             rsp_id_i,
    input  logic                           rsp_last_i,
    input  logic                           irq_clr_i,
    input  logic                           rst_stat_i,
    output logic                           full_o,
    output logic [$clog2(NumSlots+1)-1:0]  outstanding_o,
    output logic                           irq_o,
    output logic [1:0]                     irq_cause_o,
    output logic [IdWidth-1:0]             irq_id_o,
    output logic [AddrWidth-1:0]           irq_addr_o,
    output logic                           isolate_o,
    output logic                           rst_req_o
);
    localparam int SlotW = $clog2(NumSlots);
    localparam int OutW  = $clog2(NumSlots+1);

    typedef enum logic [1:0] {
        ST_MONITOR, ST_FAULT, ST_RESET, ST_WAIT
    } state_t;

    state_t r_state, w_next;

    logic [NumSlots-1:0]  r_vld;
    logic [IdWidth-1:0]   r_id   [NumSlots];
    logic [AddrWidth-1:0] r_addr [NumSlots];
    logic [CntWidth-1:0]  r_age  [NumSlots];

    logic                 r_irq;
    logic [1:0]           r_cause;
    logic [IdWidth-1:0]   r_irq_id;
    logic [AddrWidth-1:0] r_irq_addr;

    logic                 w_free_found, w_match_found, w_to_found;
    logic [SlotW-1:0]     w_free_idx, w_match_idx, w_to_idx;
    logic [CntWidth-1:0]  w_match_age;
    logic [OutW-1:0]      w_count;
    logic                 w_mon, w_req_hs, w_rsp_hs;
    logic                 w_alloc, w_free, w_flush;
    logic                 w_timeout, w_ovf, w_unm, w_fault;
    logic [1:0]           w_cause;
    logic [IdWidth-1:0]   w_fid;
    logic [AddrWidth-1:0] w_faddr;

    // Slot scans: lowest free, oldest ID match (ties to lowest), lowest timeout.
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_match_found = 1'b0;
        w_match_idx   = '0;
        w_match_age   = '0;
        w_to_found    = 1'b0;
        w_to_idx      = '0;
        w_count       = '0;
        for (int i = 0; i < NumSlots; i++) begin
            w_count = w_count + OutW'(r_vld[i]);
            if (!r_vld[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = SlotW'(i);
            end
            if (r_vld[i] && r_id[i] == rsp_id_i &&
                (!w_match_found || r_age[i] > w_match_age)) begin
                w_match_found = 1'b1;
                w_match_idx   = SlotW'(i);
                w_match_age   = r_age[i];
            end
            if (r_vld[i] && budget_i != '0 &&
                r_age[i] >= budget_i && !w_to_found) begin
                w_to_found = 1'b1;
                w_to_idx   = SlotW'(i);
            end
        end
    end

    assign full_o        = &r_vld;
    assign outstanding_o = w_count;

    assign w_mon     = (r_state == ST_MONITOR) && guard_ena_i;
    assign w_req_hs  = req_valid_i && req_ready_i;
    assign w_rsp_hs  = rsp_valid_i && rsp_ready_i && rsp_last_i;
    assign w_alloc   = w_mon && w_req_hs && !full_o && w_free_found;
    assign w_free    = w_mon && w_rsp_hs && w_match_found;
    assign w_timeout = w_mon && w_to_found;
    assign w_ovf     = w_mon && w_req_hs && full_o;
    assign w_unm     = w_mon && w_rsp_hs && !w_match_found;
    assign w_fault   = w_timeout || w_ovf || w_unm;
    assign w_flush   = ((r_state == ST_MONITOR) && !guard_ena_i) ||
                       (r_state == ST_WAIT) ||
                       ((r_state == ST_FAULT) && !AutoReset && irq_clr_i);

    always_comb begin
        w_cause = 2'd0;
        w_fid   = '0;
        w_faddr = '0;
        if (w_timeout) begin
            w_cause = 2'd1;
            w_fid   = r_id[w_to_idx];
            w_faddr = r_addr[w_to_idx];
        end else if (w_ovf) begin
            w_cause = 2'd2;
            w_fid   = req_id_i;
            w_faddr = req_addr_i;
        end else if (w_unm) begin
            w_cause = 2'd3;
            w_fid   = rsp_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                r_id[i]   <= '0;
                r_addr[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (r_state == ST_MONITOR && r_vld[i] && r_age[i] != '1)
                    r_age[i] <= r_age[i] + 1'b1;
            end
            if (w_free)
                r_vld[w_match_idx] <= 1'b0;
            if (w_alloc) begin
                r_vld[w_free_idx]  <= 1'b1;
                r_id[w_free_idx]   <= req_id_i;
                r_addr[w_free_idx] <= req_addr_i;
                r_age[w_free_idx]  <= '0;
            end
            if (w_flush)
                r_vld <= '0;
        end
    end

    // First fault wins until software clears the capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq      <= 1'b0;
            r_cause    <= 2'd0;
            r_irq_id   <= '0;
            r_irq_addr <= '0;
        end else if (irq_clr_i) begin
            r_irq      <= 1'b0;
            r_cause    <= 2'd0;
            r_irq_id   <= '0;
            r_irq_addr <= '0;
        end else if (w_fault && !r_irq) begin
            r_irq      <= 1'b1;
            r_cause    <= w_cause;
            r_irq_id   <= w_fid;
            r_irq_addr <= w_faddr;
        end
    end

    assign irq_o       = r_irq;
    assign irq_cause_o = r_cause;
    assign irq_id_o    = r_irq_id;
    assign irq_addr_o  = r_irq_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_MONITOR;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_MONITOR: if (w_fault) w_next = ST_FAULT;
            ST_FAULT: begin
                if (AutoReset)      w_next = ST_RESET;
                else if (irq_clr_i) w_next = ST_MONITOR;
            end
            ST_RESET:   if (rst_stat_i)  w_next = ST_WAIT;
            ST_WAIT:    if (!rst_stat_i) w_next = ST_MONITOR;
            default:    w_next = ST_MONITOR;
        endcase
    end

    always_comb begin
        isolate_o = (r_state != ST_MONITOR);
        rst_req_o = (r_state == ST_RESET);
    end
endmodule
